// File: rtl/truth_table_sweep_if.sv
// Handshake and result bundle between the sweep stage and its user.
// master: sweep side (drives B/C/D and results); slave: user/circuit side.
interface truth_table_sweep_if;
    logic       start;
    logic       Y;
    logic       B;
    logic       C;
    logic       D;
    logic       busy;
    logic       done;
    logic [7:0] minterms;
    logic [3:0] ones;

    modport master (
        input  start, Y,
        output B, C, D, busy, done, minterms, ones
    );

    modport slave (
        output start, Y,
        input  B, C, D, busy, done, minterms, ones
    );
endinterface

// File: rtl/truth_table_sweep.sv
// Steps {B,C,D} through 000..111, holds each HOLD cycles, captures Y.
// Ports: clk, rst (async, active-high), bus (master): start/Y in; B,C,D,busy,done,minterms,ones out.
module truth_table_sweep #(
    parameter int unsigned HOLD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_sweep_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] mint_q, mint_d;
    logic [3:0] ones_q, ones_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            mint_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            mint_q  <= mint_d;
            ones_q  <= ones_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        mint_d  = mint_q;
        ones_d  = ones_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    hold_d  = '0;
                    mint_d  = '0;
                    ones_d  = '0;
                end
            end
            APPLY: begin
                // hold_q only ever counts up from 0, so equality is enough
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    mint_d[idx_q] = bus.Y;
                    ones_d        = ones_q + {3'b000, bus.Y};
                    if (idx_q != 3'd7) begin
                        idx_d  = idx_q + 3'd1;
                        hold_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stimulus is the index register itself, so it is registered
    assign bus.B        = idx_q[2];
    assign bus.C        = idx_q[1];
    assign bus.D        = idx_q[0];
    assign bus.busy     = (state_q == APPLY);
    assign bus.done     = (state_q == DONE);
    assign bus.minterms = mint_q;
    assign bus.ones     = ones_q;
endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench: HOLD=1 instance (combinational Y) and HOLD=3 instance (delayed Y).
// Ports: none.
module tb_truth_table_sweep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;

    truth_table_sweep_if ia ();
    truth_table_sweep_if ib ();

    truth_table_sweep #(.HOLD(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    truth_table_sweep #(.HOLD(3)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    always #5 clk = ~clk;

    // mode 0: Y=1 on 001,101,111; mode 1: Y=0; mode 2: Y=1
    always_comb begin
        ia.Y = 1'b0;
        case (mode)
            0: ia.Y = ({ia.B, ia.C, ia.D} == 3'b001) ||
                      ({ia.B, ia.C, ia.D} == 3'b101) ||
                      ({ia.B, ia.C, ia.D} == 3'b111);
            1: ia.Y = 1'b0;
            default: ia.Y = 1'b1;
        endcase
    end

    // B xor D seen through two cycles of delay
    logic yd1 = 1'b0;
    logic yd2 = 1'b0;
    always @(posedge clk) begin
        yd1 <= ib.B ^ ib.D;
        yd2 <= yd1;
    end
    assign ib.Y = yd2;

    task automatic sweep_a(output int cyc);
        @(negedge clk);
        ia.start = 1'b1;
        @(posedge clk);
        #1;
        ia.start = 1'b0;
        cyc = 0;
        while (ia.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({ia.B, ia.C, ia.D, ia.busy, ia.done} !== 5'b0 ||
            ia.minterms !== 8'h00 || ia.ones !== 4'd0) begin
            bad++;
            $display("FAIL reset: bcdbd=%b min=%h ones=%0d want 0",
                     {ia.B, ia.C, ia.D, ia.busy, ia.done}, ia.minterms, ia.ones);
        end
        total++;
        if (ib.busy !== 1'b0 || ib.minterms !== 8'h00) begin
            bad++;
            $display("FAIL reset_b: busy=%b min=%h want 0", ib.busy, ib.minterms);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_parity;
        @(negedge clk);
        mode = 0;
        ia.start = 1'b1;
        @(posedge clk);
        #1;
        ia.start = 1'b0;
        total++;
        if (ia.busy !== 1'b1 || {ia.B, ia.C, ia.D} !== 3'b000) begin
            bad++;
            $display("FAIL parity_e0: busy=%b bcd=%b want 1 000",
                     ia.busy, {ia.B, ia.C, ia.D});
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (k < 8) begin
                if ({ia.B, ia.C, ia.D} !== k[2:0] || ia.busy !== 1'b1 ||
                    ia.done !== 1'b0) begin
                    bad++;
                    $display("FAIL parity_step%0d: bcd=%b busy=%b done=%b want %b 1 0",
                             k, {ia.B, ia.C, ia.D}, ia.busy, ia.done, k[2:0]);
                end
            end else begin
                if (ia.done !== 1'b1 || ia.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL parity_done: done=%b busy=%b want 1 0",
                             ia.done, ia.busy);
                end
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (ia.done !== 1'b0 || ia.minterms !== 8'hA2 || ia.ones !== 4'd3) begin
            bad++;
            $display("FAIL parity_result: done=%b min=%h ones=%0d want 0 a2 3",
                     ia.done, ia.minterms, ia.ones);
        end
    endtask

    task automatic test_settle;
        @(negedge clk);
        ib.start = 1'b1;
        @(posedge clk);
        #1;
        ib.start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (c < 24) begin
                total++;
                if ({ib.B, ib.C, ib.D} !== 3'(c / 3) || ib.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL settle_step%0d: bcd=%b busy=%b want %0d 1",
                             c, {ib.B, ib.C, ib.D}, ib.busy, c / 3);
                end
            end else begin
                total++;
                if (ib.done !== 1'b1 || ib.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL settle_done: done=%b busy=%b want 1 0",
                             ib.done, ib.busy);
                end
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (ib.done !== 1'b0 || ib.minterms !== 8'h5A || ib.ones !== 4'd4) begin
            bad++;
            $display("FAIL settle_result: done=%b min=%h ones=%0d want 0 5a 4",
                     ib.done, ib.minterms, ib.ones);
        end
    endtask

    task automatic test_const;
        int cyc;
        mode = 1;
        sweep_a(cyc);
        total++;
        if (cyc != 8 || ia.minterms !== 8'h00 || ia.ones !== 4'd0) begin
            bad++;
            $display("FAIL const0: cyc=%0d min=%h ones=%0d want 8 00 0",
                     cyc, ia.minterms, ia.ones);
        end
        mode = 2;
        sweep_a(cyc);
        total++;
        if (cyc != 8 || ia.minterms !== 8'hFF || ia.ones !== 4'd8) begin
            bad++;
            $display("FAIL const1: cyc=%0d min=%h ones=%0d want 8 ff 8",
                     cyc, ia.minterms, ia.ones);
        end
    endtask

    task automatic test_busy_start;
        @(negedge clk);
        mode = 0;
        ia.start = 1'b1;
        @(posedge clk);
        #1;
        ia.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            // pulse start for edge E0+3 and for edge E0+9 (the DONE cycle)
            if (c == 3 || c == 9) begin
                @(negedge clk);
                ia.start = 1'b1;
            end
            @(posedge clk);
            #1;
            ia.start = 1'b0;
            if (c == 3) begin
                total++;
                if ({ia.B, ia.C, ia.D} !== 3'b011 || ia.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_start: bcd=%b busy=%b want 011 1",
                             {ia.B, ia.C, ia.D}, ia.busy);
                end
            end
            if (c == 8) begin
                total++;
                if (ia.done !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_done: done=%b want 1", ia.done);
                end
            end
            if (c == 9 || c == 10) begin
                total++;
                if (ia.busy !== 1'b0 || ia.done !== 1'b0) begin
                    bad++;
                    $display("FAIL done_start%0d: busy=%b done=%b want 0 0",
                             c, ia.busy, ia.done);
                end
            end
        end
        total++;
        if (ia.minterms !== 8'hA2 || ia.ones !== 4'd3) begin
            bad++;
            $display("FAIL busy_result: min=%h ones=%0d want a2 3",
                     ia.minterms, ia.ones);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        int seen;
        @(negedge clk);
        mode = 0;
        ia.start = 1'b1;
        @(posedge clk);
        #1;
        ia.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({ia.B, ia.C, ia.D} !== 3'b100 || ia.minterms !== 8'h02) begin
            bad++;
            $display("FAIL areset_pre: bcd=%b min=%h want 100 02",
                     {ia.B, ia.C, ia.D}, ia.minterms);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({ia.B, ia.C, ia.D, ia.busy, ia.done} !== 5'b0 ||
            ia.minterms !== 8'h00 || ia.ones !== 4'd0) begin
            bad++;
            $display("FAIL areset_now: bcdbd=%b min=%h ones=%0d want 0",
                     {ia.B, ia.C, ia.D, ia.busy, ia.done}, ia.minterms, ia.ones);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ia.done === 1'b1 || ia.busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL areset_quiet: active cycles=%0d want 0", seen);
        end
        sweep_a(cyc);
        total++;
        if (cyc != 8 || ia.minterms !== 8'hA2 || ia.ones !== 4'd3) begin
            bad++;
            $display("FAIL areset_clean: cyc=%0d min=%h ones=%0d want 8 a2 3",
                     cyc, ia.minterms, ia.ones);
        end
    endtask

    task automatic test_back_to_back;
        int dn[$];
        @(negedge clk);
        mode = 0;
        ia.start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ia.done === 1'b1) dn.push_back(c);
            if (c == 10) begin
                total++;
                if (ia.minterms !== 8'h00 || ia.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_clear: min=%h busy=%b want 00 1",
                             ia.minterms, ia.busy);
                end
            end
            if (c == 9) begin
                total++;
                if (ia.minterms !== 8'hA2 || ia.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle: min=%h busy=%b want a2 0",
                             ia.minterms, ia.busy);
                end
            end
        end
        ia.start = 1'b0;
        total++;
        if (dn.size() != 3 || dn[0] != 8 || dn[1] != 18 || dn[2] != 28) begin
            bad++;
            $display("FAIL b2b_period: n=%0d first=%0d want 3 at 8,18,28",
                     dn.size(), (dn.size() > 0) ? dn[0] : -1);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        ia.start = 1'b0;
        ib.start = 1'b0;
        test_reset();
        test_parity();
        test_settle();
        test_const();
        test_busy_start();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
